// File: rtl/debounce_pkg.sv
// debounce_pkg
// Shared constants for the push-button debouncer: key polarity encodings
// and the default stability window length.
package debounce_pkg;

  // Keys are active-low: a pressed button pulls the line to ground.
  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;

  // Two cycles of the 100 Hz system tick gives a 20 ms debounce window.
  localparam int STABLE_CYCLES_DEFAULT = 2;

endpackage : debounce_pkg

// File: rtl/debounce_channel.sv
// debounce_channel
// One debounced key. The raw level is brought into the clk domain through
// a two-flop synchronizer. It is accepted as the new stable level only
// after it has differed from the current stable level for STABLE_CYCLES
// consecutive edges. A one-cycle pulse is issued on each accepted press.
//
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous, active-high reset
//   key       - raw button level, active-low, asynchronous to clk
//   key_pulse - registered single-cycle pulse per debounced press
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic key_pulse
);

  // The counter never exceeds this value: reaching it on a mismatch
  // accepts the new level and clears the counter in the same edge.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_r;
  logic             s2_r;
  logic             stb_r;
  logic [CNT_W-1:0] cnt_r;
  logic             pulse_r;

  logic [CNT_W-1:0] cnt_s;
  logic             stb_s;
  logic             pulse_s;

  // Two-flop synchronizer; resets to the released level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r <= KEY_RELEASED;
      s2_r <= KEY_RELEASED;
    end else begin
      s1_r <= key;
      s2_r <= s1_r;
    end
  end

  // Stability counter, stable level and press-pulse next-state logic.
  always_comb begin
    cnt_s   = {CNT_W{1'b0}};
    stb_s   = stb_r;
    pulse_s = 1'b0;
    if (s2_r == stb_r) begin
      // Level agrees with the stable state: any partial run is discarded.
      cnt_s = {CNT_W{1'b0}};
    end else if (cnt_r < CNT_MAX) begin
      cnt_s = cnt_r + CNT_W'(1);
    end else begin
      // Run long enough: accept the new level. Only 1->0 is a press.
      stb_s   = s2_r;
      cnt_s   = {CNT_W{1'b0}};
      pulse_s = (s2_r == KEY_PRESSED) ? 1'b1 : 1'b0;
    end
  end

  // Debounce state and registered pulse output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stb_r   <= KEY_RELEASED;
      cnt_r   <= {CNT_W{1'b0}};
      pulse_r <= 1'b0;
    end else begin
      stb_r   <= stb_s;
      cnt_r   <= cnt_s;
      pulse_r <= pulse_s;
    end
  end

  assign key_pulse = pulse_r;

endmodule : debounce_channel

// File: rtl/debounce_ii.sv
// debounce_ii
// Multi-channel push-button debouncer with press-edge detection. Each of
// the N active-low keys is handled by an independent debounce_channel.
//
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous, active-high reset
//   key       - N raw button levels, active-low, asynchronous to clk
//   key_pulse - N registered one-cycle pulses, one per debounced press
module debounce_ii
  import debounce_pkg::*;
#(
  parameter int N             = 1,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] key,
  output logic [N-1:0] key_pulse
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .key       (key[i]),
      .key_pulse (key_pulse[i])
    );
  end

endmodule : debounce_ii

// File: tb/tb_debounce_ii.sv
// tb_debounce_ii
// Self-checking bench for debounce_ii with N=4, STABLE_CYCLES=4. Directed
// scenarios are followed by randomized key activity; every cycle the DUT
// pulses are compared with a window-based reference model.
module tb_debounce_ii;

  localparam int N  = 4;
  localparam int SC = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] key;
  logic [N-1:0] key_pulse;

  int checks;
  int failures;
  int cyc;
  int pulse_cnt [N];
  int first_pulse [N];

  // Reference model: history of key samples taken at each edge, newest
  // first. The level seen by the filter at an edge is the sample from two
  // edges earlier; the stable level flips when the last SC such levels
  // all differ from it.
  logic [N-1:0] hist [$];
  logic [N-1:0] m_stb;
  logic [N-1:0] exp_pulse;

  debounce_ii #(
    .N             (N),
    .STABLE_CYCLES (SC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .key_pulse (key_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < SC + 2; i++) hist.push_front({N{1'b1}});
    m_stb     = {N{1'b1}};
    exp_pulse = {N{1'b0}};
  endtask

  task automatic model_edge(input logic [N-1:0] k);
    logic [N-1:0] nxt;
    nxt = {N{1'b0}};
    for (int ch = 0; ch < N; ch++) begin
      bit all_diff;
      all_diff = 1'b1;
      for (int j = 0; j < SC; j++)
        if (hist[1 + j][ch] == m_stb[ch]) all_diff = 1'b0;
      if (all_diff) begin
        m_stb[ch] = ~m_stb[ch];
        if (m_stb[ch] == 1'b0) nxt[ch] = 1'b1;
      end
    end
    exp_pulse = nxt;
    hist.push_front(k);
    void'(hist.pop_back());
  endtask

  // One clock cycle: drive inputs, take the edge, compare at the falling edge.
  task automatic cycle(input logic [N-1:0] k, input logic r);
    key = k;
    rst = r;
    if (r) model_reset();
    @(posedge clk);
    if (!r) model_edge(k);
    @(negedge clk);
    cyc++;
    check_eq("pulse", 32'(key_pulse), 32'(exp_pulse));
    for (int ch = 0; ch < N; ch++) begin
      if (key_pulse[ch] === 1'b1) begin
        pulse_cnt[ch]++;
        if (first_pulse[ch] < 0) first_pulse[ch] = cyc;
      end
    end
  endtask

  task automatic mark();
    for (int ch = 0; ch < N; ch++) begin
      pulse_cnt[ch]   = 0;
      first_pulse[ch] = -1;
    end
  endtask

  task automatic run(input logic [N-1:0] k, input int n);
    for (int i = 0; i < n; i++) cycle(k, 1'b0);
  endtask

  initial begin
    int base;
    logic [N-1:0] lvl;
    int rem [N];

    checks   = 0;
    failures = 0;
    cyc      = 0;
    key      = {N{1'b1}};
    rst      = 1'b1;
    model_reset();
    mark();

    // Reset: no pulse during reset or the following 20 cycles.
    for (int i = 0; i < 3; i++) cycle(4'b1111, 1'b1);
    check_eq("rst_out", 32'(key_pulse), 32'd0);
    run(4'b1111, 20);
    check_eq("rst_quiet", 32'(pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3]), 32'd0);

    // Clean press on channel 0: pulse after the 6th edge, then quiet.
    mark();
    base = cyc;
    run(4'b1110, 20);
    check_eq("clean_cnt", 32'(pulse_cnt[0]), 32'd1);
    check_eq("clean_lat", 32'(first_pulse[0] - base), 32'd6);

    // Release: no pulse.
    mark();
    run(4'b1111, 10);
    check_eq("release_cnt", 32'(pulse_cnt[0]), 32'd0);

    // Bounce rejection: 3 low, 1 high, 3 low, then high.
    mark();
    run(4'b1110, 3);
    run(4'b1111, 1);
    run(4'b1110, 3);
    run(4'b1111, 6);
    check_eq("bounce_cnt", 32'(pulse_cnt[0]), 32'd0);

    // Held press after bounce (second press after release): one pulse.
    mark();
    base = cyc;
    run(4'b1110, 10);
    check_eq("hold_cnt", 32'(pulse_cnt[0]), 32'd1);
    check_eq("hold_lat", 32'(first_pulse[0] - base), 32'd6);

    // Reset two cycles into a held press; key kept low afterwards.
    run(4'b1111, 10);
    mark();
    run(4'b1110, 2);
    cycle(4'b1110, 1'b1);
    cycle(4'b1110, 1'b1);
    check_eq("midrst_none", 32'(pulse_cnt[0]), 32'd0);
    base = cyc;
    run(4'b1110, 12);
    check_eq("midrst_cnt", 32'(pulse_cnt[0]), 32'd1);
    check_eq("midrst_lat", 32'(first_pulse[0] - base), 32'd6);

    // Multi-channel: bits 0 and 2 together, bit 3 five cycles later.
    run(4'b1111, 10);
    mark();
    base = cyc;
    run(4'b1010, 5);
    run(4'b0010, 15);
    check_eq("multi_ch0_lat", 32'(first_pulse[0] - base), 32'd6);
    check_eq("multi_ch2_lat", 32'(first_pulse[2] - base), 32'd6);
    check_eq("multi_ch3_lat", 32'(first_pulse[3] - base), 32'd11);
    check_eq("multi_ch1_cnt", 32'(pulse_cnt[1]), 32'd0);
    check_eq("multi_ch3_cnt", 32'(pulse_cnt[3]), 32'd1);

    // Randomized runs of varying length per channel, occasional reset.
    lvl = 4'b1111;
    for (int ch = 0; ch < N; ch++) rem[ch] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (rem[ch] == 0) begin
          lvl[ch] = ~lvl[ch];
          rem[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 14) : $urandom_range(1, 5);
        end
        rem[ch]--;
      end
      cycle(lvl, ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0);
    end
    cycle(lvl, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_debounce_ii

// File: doc/debounce_ii.md
# debounce_ii

Multi-channel push-button debouncer with press-edge detection. Each of N asynchronous, active-low key inputs is synchronized, filtered until it has held a new level for a programmable number of clock cycles, and converted into a single-cycle `key_pulse` on each debounced press. It sits between board buttons and control logic, such as counter start/stop toggles, that must react exactly once per physical press.

## Interface
- `N`, default 1: number of independent key channels.
- `STABLE_CYCLES`, default 2: consecutive cycles a changed level must persist before it is accepted (minimum 1). Two cycles gives 20 ms at the 100 Hz system tick.
- `CNT_W`, default `$clog2(STABLE_CYCLES+1)`: width of the per-channel stability counter.
- `clk`, input, 1: clock; all logic is rising-edge triggered.
- `rst`, input, 1: reset, asynchronous, active-high.
- `key`, input, N: raw button levels, active-low (0 = pressed), asynchronous to `clk`.
- `key_pulse`, output, N: registered, one `clk`-cycle-high pulse per debounced press, per bit.

## Operation
- Each channel is independent and identical, with no cross-channel interaction.
- **Synchronizer:** two flops per bit, s1 then s2. Both reset to 1 (released).
- **Stable state** `stb`: the debounced level. It resets to 1.
- **Counter** `cnt`, per channel, resets to 0. On each edge:
  - If s2 == stb: `cnt` becomes 0.
  - If s2 != stb and cnt < STABLE_CYCLES-1: `cnt` increments.
  - If s2 != stb and cnt == STABLE_CYCLES-1: `stb` takes s2 and `cnt` becomes 0.
- **Pulse:** `key_pulse` is 1 for the cycle after the edge on which `stb` changes from 1 to 0. It is 0 otherwise.
- A debounced release (0 to 1) updates `stb` but never produces a pulse.
- A key held pressed indefinitely produces exactly one pulse.
- Bounce shorter than STABLE_CYCLES consecutive cycles at s2 clears the counter. `stb` does not change and no pulse is produced.
- Counter arithmetic is unsigned and never wraps; it saturates by construction at STABLE_CYCLES-1.

## Timing
- **Reset values:**
  - `key_pulse` = 0.
  - s1, s2 and `stb` = all ones.
  - `cnt` = 0.
- **Reset mid-debounce:** all state returns to its reset value and no pulse is produced. After release of `rst`, a key still held low is re-qualified from scratch and yields one pulse.
- **Press latency:**
  - Edge e0: `key` is first sampled low into s1.
  - Edge e1: s2 goes low.
  - Edges e2 through e(STABLE_CYCLES+1): the level is counted.
  - After edge e(STABLE_CYCLES+1): `key_pulse` is high for exactly one cycle, i.e. STABLE_CYCLES+2 edges after first sampling.
- **Back-to-back presses:** a press requires a qualified release in between, so the minimum spacing between pulses on one channel is 2·STABLE_CYCLES cycles.
- **Simultaneous events:** channels pressed on the same edge pulse on the same cycle.

## Structure
- Shared package `debounce_pkg`:
  - `KEY_PRESSED` = 1'b0.
  - `KEY_RELEASED` = 1'b1.
  - Default `STABLE_CYCLES` constant.
- Sub-module `debounce_channel`: one bit, containing the synchronizer, counter, stable state and pulse register. It is instantiated N times in a generate loop by `debounce_ii`.

## Test plan
All scenarios use STABLE_CYCLES=4.
- **Reset:** assert `rst` with `key`=all ones. `key_pulse`=0 throughout reset and for the following 20 cycles.
- **Clean press:** N=1, drive `key` 1→0 before edge e0 and hold it. `key_pulse`=1 for exactly one cycle, after edge e5 (6th edge), then stays 0 while held.
- **Bounce rejection:** `key` low for 3 cycles, high for 1, low for 3, then high. No pulse. Then hold low for 10 cycles: exactly one pulse, 6 edges after the last low-going transition.
- **Release:** after a qualified press, drive `key` high for 10 cycles. No pulse. A second press then gives one pulse.
- **Reset mid-operation:** assert `rst` 2 cycles into a held press, release it, keep `key` low. One pulse, 6 edges after `rst` deasserts.
- **Multi-channel:** N=4, press bits 0 and 2 on the same edge and bit 3 five cycles later. Bits 0 and 2 pulse on the same cycle, bit 3 pulses 5 cycles after, and bit 1 never pulses.
